// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions used by the load-extension stage.
//   XLEN          datapath width (only 32 is supported)
//   F3_*          RISC-V load funct3 encodings
//   load_kind_e   decoded load kind, including an illegal marker
//   decode_load   funct3 -> load_kind_e; anything unrecognised (including X) is illegal
package rv_core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    LK_LB,
    LK_LH,
    LK_LW,
    LK_LBU,
    LK_LHU,
    LK_ILLEGAL
  } load_kind_e;

  function automatic load_kind_e decode_load(input logic [2:0] f3);
    case (f3)
      F3_LB:   return LK_LB;
      F3_LH:   return LK_LH;
      F3_LW:   return LK_LW;
      F3_LBU:  return LK_LBU;
      F3_LHU:  return LK_LHU;
      default: return LK_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_unit_if.sv
// Bus bundle between the memory-return path and the load-extension stage.
//   in_valid, data, sel, addr_lo : request side (driven by master)
//   out_valid, trimm, illegal    : registered result side (driven by slave)
// Modports: master = producer of load words, slave = load_ext_unit.
interface load_ext_unit_if;
  import rv_core_pkg::*;

  logic            in_valid;
  logic [XLEN-1:0] data;
  logic [2:0]      sel;
  logic [1:0]      addr_lo;
  logic            out_valid;
  logic [XLEN-1:0] trimm;
  logic            illegal;

  modport master (
    output in_valid, data, sel, addr_lo,
    input  out_valid, trimm, illegal
  );

  modport slave (
    input  in_valid, data, sel, addr_lo,
    output out_valid, trimm, illegal
  );

endinterface

// File: rtl/load_lane_select.sv
// Combinational lane picker for the load-extension stage.
//   data      in  raw 32-bit load word
//   sel       in  load funct3
//   addr_lo   in  byte offset of the load address
//   byte_lane out selected byte
//   half_lane out selected halfword
//   misalign  out access is misaligned for its size
// Optional feature macro: LOAD_ALIGN_EN. When undefined, lanes are fixed at the
// low bits (memory pre-shifts the data) and misalign is never raised.
module load_lane_select
  import rv_core_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      sel,
  input  logic [1:0]      addr_lo,
  output logic [7:0]      byte_lane,
  output logic [15:0]     half_lane,
  output logic            misalign
);

`ifdef LOAD_ALIGN_EN
  always_comb begin
    byte_lane = data[7:0];
    case (addr_lo)
      2'd1:    byte_lane = data[15:8];
      2'd2:    byte_lane = data[23:16];
      2'd3:    byte_lane = data[31:24];
      default: byte_lane = data[7:0];
    endcase

    half_lane = addr_lo[1] ? data[31:16] : data[15:0];

    misalign = 1'b0;
    case (sel)
      F3_LH, F3_LHU: misalign = addr_lo[0];
      F3_LW:         misalign = |addr_lo;
      default:       misalign = 1'b0;
    endcase
  end
`else
  logic unused_lane_inputs;

  assign byte_lane = data[7:0];
  assign half_lane = data[15:0];
  assign misalign  = 1'b0;
  assign unused_lane_inputs = ^{data[31:16], sel, addr_lo};
`endif

endmodule

// File: rtl/load_ext_unit.sv
// Load-data extension stage between data memory and writeback.
// Trims the memory word to byte/half/word by load funct3, sign- or zero-extends
// to XLEN, and registers the result (1-cycle latency).
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of load_ext_unit_if:
//          in_valid/data/sel/addr_lo in, out_valid/trimm/illegal out
// Optional feature macro: LOAD_ALIGN_EN (lane selection by addr_lo plus
// misalignment detection, implemented in load_lane_select).
module load_ext_unit #(
  parameter int unsigned XLEN = rv_core_pkg::XLEN
) (
  input  logic           clk,
  input  logic           rst,
  load_ext_unit_if.slave bus
);
  import rv_core_pkg::*;

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic            misalign;
  load_kind_e      kind;
  logic [XLEN-1:0] trimm_d;
  logic            illegal_d;

  load_lane_select u_lane (
    .data      (bus.data),
    .sel       (bus.sel),
    .addr_lo   (bus.addr_lo),
    .byte_lane (byte_lane),
    .half_lane (half_lane),
    .misalign  (misalign)
  );

  always_comb begin
    trimm_d   = '0;
    illegal_d = 1'b0;
    kind      = decode_load(bus.sel);
    case (kind)
      LK_LB:   trimm_d = {{24{byte_lane[7]}}, byte_lane};
      LK_LH:   trimm_d = {{16{half_lane[15]}}, half_lane};
      LK_LW:   trimm_d = bus.data;
      LK_LBU:  trimm_d = {24'h0, byte_lane};
      LK_LHU:  trimm_d = {16'h0, half_lane};
      default: illegal_d = 1'b1;
    endcase
    if (misalign) begin
      trimm_d   = '0;
      illegal_d = 1'b1;
    end
  end

  // trimm/illegal only load on a valid beat, so they hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.trimm     <= '0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.trimm   <= trimm_d;
        bus.illegal <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
module tb_load_ext_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_ext_unit_if bus ();

  load_ext_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic        exp_valid   = 1'b0;
  logic [31:0] exp_trimm   = 32'h0;
  logic        exp_illegal = 1'b0;

`ifdef LOAD_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // Reference: returns {illegal, trimm} from the load rules using plain arithmetic.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [2:0] s,
                                        input logic [1:0] a);
    int unsigned boff;
    int unsigned hoff;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] r;
    bit ill;
    bit mis;
    boff = ALIGN_EN ? int'(a) : 0;
    hoff = ALIGN_EN ? int'(a) / 2 : 0;
    mis  = ALIGN_EN && ((((s == 3'd1) || (s == 3'd5)) && (a % 2 == 1)) ||
                        ((s == 3'd2) && (a != 0)));
    b = (d >> (8 * boff)) & 32'hFF;
    h = (d >> (16 * hoff)) & 32'hFFFF;
    ill = 1'b0;
    r = 32'h0;
    case (s)
      3'd0: r = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: r = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2: r = d;
      3'd4: r = b;
      3'd5: r = h;
      default: ill = 1'b1;
    endcase
    if (mis) begin
      ill = 1'b1;
      r = 32'h0;
    end
    return {ill, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic step(input string tag, input logic r, input logic v, input logic [31:0] d,
                      input logic [2:0] s, input logic [1:0] a);
    logic [32:0] m;
    rst = r;
    bus.in_valid = v;
    bus.data = d;
    bus.sel = s;
    bus.addr_lo = a;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid = 1'b0;
      exp_trimm = 32'h0;
      exp_illegal = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        m = model(d, s, a);
        exp_trimm = m[31:0];
        exp_illegal = m[32];
      end
    end
    check({tag, ".valid"},   {31'h0, bus.out_valid}, {31'h0, exp_valid});
    check({tag, ".trimm"},   bus.trimm, exp_trimm);
    check({tag, ".illegal"}, {31'h0, bus.illegal}, {31'h0, exp_illegal});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.data = 32'h0;
    bus.sel = 3'b0;
    bus.addr_lo = 2'b0;

    step("reset0", 1'b1, 1'b0, 32'h0, 3'd0, 2'd0);
    step("reset1", 1'b1, 1'b1, 32'hFFFF_FFFF, 3'd0, 2'd0);
    check("reset.trimm_const", bus.trimm, 32'h0);

    step("t1_lb", 1'b0, 1'b1, 32'h0000_0080, 3'b000, 2'd0);
    check("t1_lb_const", bus.trimm, 32'hFFFF_FF80);
    step("t1_lbu", 1'b0, 1'b1, 32'h0000_0080, 3'b100, 2'd0);
    check("t1_lbu_const", bus.trimm, 32'h0000_0080);
    step("t2_lh", 1'b0, 1'b1, 32'h0000_8001, 3'b001, 2'd0);
    check("t2_lh_const", bus.trimm, 32'hFFFF_8001);
    step("t2_lhu", 1'b0, 1'b1, 32'h0000_8001, 3'b101, 2'd0);
    check("t2_lhu_const", bus.trimm, 32'h0000_8001);
    step("t3_lw", 1'b0, 1'b1, 32'hDEAD_BEEF, 3'b010, 2'd0);
    check("t3_lw_const", bus.trimm, 32'hDEAD_BEEF);
    step("t3_lb", 1'b0, 1'b1, 32'hDEAD_BEEF, 3'b000, 2'd0);
    check("t3_lb_const", bus.trimm, 32'hFFFF_FFEF);
    step("t3_lh", 1'b0, 1'b1, 32'hDEAD_BEEF, 3'b001, 2'd0);
    check("t3_lh_const", bus.trimm, 32'hFFFF_BEEF);

    step("t4_011", 1'b0, 1'b1, 32'h1234_5678, 3'b011, 2'd0);
    check("t4_011_ill", {31'h0, bus.illegal}, 32'h1);
    step("t4_110", 1'b0, 1'b1, 32'hFFFF_FFFF, 3'b110, 2'd0);
    step("t4_111", 1'b0, 1'b1, 32'h8000_0001, 3'b111, 2'd0);
    check("t4_111_trimm", bus.trimm, 32'h0);

    // Idle cycles hold trimm/illegal, then a legal load clears illegal.
    step("hold0", 1'b0, 1'b0, 32'hAAAA_AAAA, 3'b010, 2'd0);
    step("hold1", 1'b0, 1'b0, 32'h5555_5555, 3'b000, 2'd0);
    step("after_hold", 1'b0, 1'b1, 32'h0000_007F, 3'b000, 2'd0);

    // Reset mid-stream beats in_valid; X on sel must not leak into reset state.
    step("t5_pre", 1'b0, 1'b1, 32'hCAFE_F00D, 3'b010, 2'd0);
    step("t5_rst", 1'b1, 1'b1, 32'h1111_1111, 3'b010, 2'd0);
    step("t5_rstx", 1'b1, 1'b1, 32'h2222_2222, 3'bxxx, 2'd0);
    step("t5_b2b0", 1'b0, 1'b1, 32'h0000_00FF, 3'b000, 2'd0);
    step("t5_b2b1", 1'b0, 1'b1, 32'h0000_FFFF, 3'b101, 2'd0);
    step("t5_b2b2", 1'b0, 1'b1, 32'h7654_3210, 3'b010, 2'd0);

`ifdef LOAD_ALIGN_EN
    step("t6_lb3", 1'b0, 1'b1, 32'h80FF_7F01, 3'b000, 2'd3);
    check("t6_lb3_const", bus.trimm, 32'hFFFF_FF80);
    step("t6_lh1", 1'b0, 1'b1, 32'h80FF_7F01, 3'b001, 2'd1);
    check("t6_lh1_ill", {31'h0, bus.illegal}, 32'h1);
    check("t6_lh1_trimm", bus.trimm, 32'h0);
    step("t6_lhu2", 1'b0, 1'b1, 32'h80FF_7F01, 3'b101, 2'd2);
    step("t6_lw2", 1'b0, 1'b1, 32'h80FF_7F01, 3'b010, 2'd2);
`else
    step("noalign_lb3", 1'b0, 1'b1, 32'h80FF_7F01, 3'b000, 2'd3);
    check("noalign_lb3_const", bus.trimm, 32'h0000_0001);
    step("noalign_lw1", 1'b0, 1'b1, 32'h80FF_7F01, 3'b010, 2'd1);
    check("noalign_lw1_const", bus.trimm, 32'h80FF_7F01);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [2:0] s;
      logic r;
      logic v;
      s = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      step("rand", r, v, $urandom, s, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
